// File: rtl/coo_dec_hls_deadlock_reporter.sv
// Deadlock reporter: qualifies the monitor's raw block flag with a
// programmable persistence timeout, snapshots the AXIS block vector with a
// timestamp on a confirmed deadlock, and delivers it as one valid/ready beat.
// The deadlock flag stays set until software pulses clear.
module coo_dec_hls_deadlock_reporter #(
  parameter int NUM_AXIS  = 4,
  parameter int TIMEOUT_W = 16,
  parameter int TS_W      = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     block_in,
  input  logic [NUM_AXIS-1:0]      axis_block_sigs,
  input  logic [TIMEOUT_W-1:0]     timeout_cfg,
  input  logic                     clear,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [TS_W+NUM_AXIS-1:0] rpt_data,
  output logic                     deadlock,
  output logic [7:0]               event_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [TIMEOUT_W-1:0]      persist_q, persist_d;
  logic [TS_W-1:0]           ts_q;
  logic [TS_W+NUM_AXIS-1:0]  rpt_data_q, rpt_data_d;
  logic                      deadlock_q, deadlock_d;
  logic [7:0]                event_count_q, event_count_d;

  logic [TIMEOUT_W-1:0]      timeout_eff;
  logic [TIMEOUT_W-1:0]      persist_last;
  logic                      capture;

  // A zero timeout would never fire, so it behaves like a one-cycle timeout;
  // the counter stops one short of T because the T-th sample itself captures.
  assign timeout_eff  = (timeout_cfg == '0) ? TIMEOUT_W'(1) : timeout_cfg;
  assign persist_last = timeout_eff - TIMEOUT_W'(1);

  // Free-running timestamp; only reset touches it, clear does not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  // Next-state logic: clear overrides everything, capture loads the report.
  always_comb begin
    state_d       = state_q;
    persist_d     = persist_q;
    rpt_data_d    = rpt_data_q;
    deadlock_d    = deadlock_q;
    event_count_d = event_count_q;
    capture       = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      persist_d  = '0;
      deadlock_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          persist_d = '0;
          if (block_in) begin
            if (timeout_eff == TIMEOUT_W'(1)) begin
              capture = 1'b1;
            end else begin
              persist_d = TIMEOUT_W'(1);
              state_d   = COUNT;
            end
          end
        end
        COUNT: begin
          if (!block_in) begin
            persist_d = '0;
            state_d   = IDLE;
          end else if (persist_q >= persist_last) begin
            capture = 1'b1;
          end else begin
            persist_d = persist_q + TIMEOUT_W'(1);
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (capture) begin
        state_d    = REPORT;
        persist_d  = '0;
        rpt_data_d = {ts_q, axis_block_sigs};
        deadlock_d = 1'b1;
        if (event_count_q != 8'hFF) begin
          event_count_d = event_count_q + 8'd1;
        end
      end
    end
  end

  // State and report registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      persist_q     <= '0;
      rpt_data_q    <= '0;
      deadlock_q    <= 1'b0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      persist_q     <= persist_d;
      rpt_data_q    <= rpt_data_d;
      deadlock_q    <= deadlock_d;
      event_count_q <= event_count_d;
    end
  end

  // Valid is decoded from the state so an async reset drops it at once.
  assign rpt_valid   = (state_q == REPORT);
  assign rpt_data    = rpt_data_q;
  assign deadlock    = deadlock_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_coo_dec_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter. Expected report beats are
// queued when the qualifying block sample is driven and popped when the
// DUT presents rpt_valid.
module tb_coo_dec_hls_deadlock_reporter;

  localparam int NUM_AXIS  = 4;
  localparam int TIMEOUT_W = 16;
  localparam int TS_W      = 32;
  localparam int DW        = TS_W + NUM_AXIS;

  logic                 clock;
  logic                 reset_n;
  logic                 block_in;
  logic [NUM_AXIS-1:0]  axis_block_sigs;
  logic [TIMEOUT_W-1:0] timeout_cfg;
  logic                 clear;
  logic                 rpt_valid;
  logic                 rpt_ready;
  logic [DW-1:0]        rpt_data;
  logic                 deadlock;
  logic [7:0]           event_count;

  int nAssert = 0;
  int nFail   = 0;

  logic [DW-1:0] expQ[$];
  logic [31:0]   tsModel;

  coo_dec_hls_deadlock_reporter #(
    .NUM_AXIS (NUM_AXIS),
    .TIMEOUT_W(TIMEOUT_W),
    .TS_W     (TS_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .block_in       (block_in),
    .axis_block_sigs(axis_block_sigs),
    .timeout_cfg    (timeout_cfg),
    .clear          (clear),
    .rpt_valid      (rpt_valid),
    .rpt_ready      (rpt_ready),
    .rpt_data       (rpt_data),
    .deadlock       (deadlock),
    .event_count    (event_count)
  );

  // 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference timestamp: number of rising edges since reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tsModel <= '0;
    else          tsModel <= tsModel + 32'd1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pops the next expected beat and compares it with the presented beat.
  task automatic checkReport(input string tag);
    logic [DW-1:0] exp;
    checkOutput({tag, "_valid"}, 64'(rpt_valid), 64'd1);
    nAssert++;
    assert (expQ.size() > 0) else begin
      nFail++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      checkOutput({tag, "_data"}, 64'(rpt_data), 64'(exp));
    end
  endtask

  // Drives one cycle of inputs at the falling edge; outputs seen right after
  // reflect the previous rising edge.
  task automatic applyStimulus(input logic blk, input logic [NUM_AXIS-1:0] sigs,
                               input logic rdy, input logic clr);
    @(negedge clock);
    block_in        = blk;
    axis_block_sigs = sigs;
    rpt_ready       = rdy;
    clear           = clr;
  endtask

  initial begin : stim
    logic          sawValid;
    int            validCnt;
    int            hsCnt;
    logic          stable;
    logic [DW-1:0] firstData;

    reset_n         = 1'b0;
    block_in        = 1'b0;
    axis_block_sigs = '0;
    timeout_cfg     = 16'd5;
    clear           = 1'b0;
    rpt_ready       = 1'b0;

    // Reset values.
    #1;
    checkOutput("rst_valid", 64'(rpt_valid), 64'd0);
    checkOutput("rst_deadlock", 64'(deadlock), 64'd0);
    checkOutput("rst_count", 64'(event_count), 64'd0);
    checkOutput("rst_data", 64'(rpt_data), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Glitch rejection: 4 high, 1 low, 4 high never reaches T=5.
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus((i != 4) && (i < 9), 4'b1111, 1'b1, 1'b0);
      sawValid |= rpt_valid;
    end
    checkOutput("glitch_valid", 64'(sawValid), 64'd0);
    checkOutput("glitch_deadlock", 64'(deadlock), 64'd0);
    checkOutput("glitch_count", 64'(event_count), 64'd0);

    // Persistence and report with T=5, sink always ready.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, (i == 4) ? 4'b0110 : 4'b0001, 1'b1, 1'b0);
      if (i == 4) begin
        checkOutput("persist_pre_valid", 64'(rpt_valid), 64'd0);
        expQ.push_back({tsModel, 4'b0110});
      end
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkReport("persist_rpt");
    checkOutput("persist_deadlock", 64'(deadlock), 64'd1);
    checkOutput("persist_count", 64'(event_count), 64'd1);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    checkOutput("persist_hs_done", 64'(rpt_valid), 64'd0);
    checkOutput("persist_hold_deadlock", 64'(deadlock), 64'd1);

    // Clear returns to idle and keeps the count and last report.
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("clear_deadlock", 64'(deadlock), 64'd0);
    checkOutput("clear_count_kept", 64'(event_count), 64'd1);
    checkOutput("clear_snap_kept", 64'(rpt_data[3:0]), 64'h6);

    // Backpressure: sink stalls 10 cycles, then accepts.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0);
    end
    expQ.push_back({tsModel, 4'b1010});
    validCnt  = 0;
    hsCnt     = 0;
    stable    = 1'b1;
    firstData = '0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 4'b0101, (i >= 10), 1'b0);
      if (i == 0) begin
        checkReport("bp_rpt");
        firstData = rpt_data;
      end
      if (rpt_valid) begin
        validCnt++;
        if (rpt_data !== firstData) stable = 1'b0;
        if (rpt_ready) hsCnt++;
      end
    end
    checkOutput("bp_valid_cycles", 64'(validCnt), 64'd11);
    checkOutput("bp_handshakes", 64'(hsCnt), 64'd1);
    checkOutput("bp_data_stable", 64'(stable), 64'd1);
    checkOutput("bp_hold_deadlock", 64'(deadlock), 64'd1);
    checkOutput("bp_count", 64'(event_count), 64'd2);

    // Clear and re-arm with T=3.
    timeout_cfg = 16'd3;
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    checkOutput("rearm_deadlock_low", 64'(deadlock), 64'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0011, 1'b1, 1'b0);
    expQ.push_back({tsModel, 4'b0011});
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkReport("rearm_rpt");
    checkOutput("rearm_count", 64'(event_count), 64'd3);

    // Boundary timeouts 0 and 1 with a single-cycle pulse.
    for (int k = 0; k < 2; k++) begin
      timeout_cfg = 16'(k);
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
      applyStimulus(1'b1, (k == 0) ? 4'b1000 : 4'b0100, 1'b1, 1'b0);
      expQ.push_back({tsModel, (k == 0) ? 4'b1000 : 4'b0100});
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
      checkReport((k == 0) ? "t0_rpt" : "t1_rpt");
    end
    checkOutput("boundary_count", 64'(event_count), 64'd5);

    // Saturation: 300 detect/clear rounds; the clear coincides with handshake.
    timeout_cfg = 16'd1;
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("sat_count", 64'(event_count), 64'd255);
    checkOutput("sat_deadlock", 64'(deadlock), 64'd0);

    // Async reset while a beat is pending.
    applyStimulus(1'b1, 4'b1001, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("ar_pre_valid", 64'(rpt_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(rpt_valid), 64'd0);
    checkOutput("ar_deadlock", 64'(deadlock), 64'd0);
    checkOutput("ar_count", 64'(event_count), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b1, 4'b1001, 1'b1, 1'b0);
    expQ.push_back({32'd1, 4'b1001});
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkReport("ar_ts_restart");
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);

    nAssert++;
    assert (expQ.size() == 0) else begin
      nFail++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
